// File: rtl/calculator_pkg.sv
// calculator_pkg: shared widths and FSM state encoding for the calculator datapath.
//    DATA_W        operand/result width
//    MEM_WORD_SIZE SRAM word width (two operands, or two packed results)
//    ADDR_W        SRAM address width
//    state_t       sequencing states of calc_controller
package calculator_pkg;
   localparam int DATA_W        = 32;
   localparam int MEM_WORD_SIZE = 64;
   localparam int ADDR_W        = 10;
   typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_ADD, S_FLUSH, S_WRITE, S_END} state_t;
endpackage

// File: rtl/calc_controller.sv
// calc_controller: walks operand words in SRAM, feeds the adder, packs two sums per result word and writes it back.
//    clk_i, rst_ni                      clock, asynchronous active-low reset
//    start_i                            begin a run (only honoured in S_IDLE)
//    rd_start_i/rd_end_i                inclusive operand word range, sampled on start
//    wr_start_i/wr_end_i                inclusive result word range, sampled on start
//    mem_rdata_i                        SRAM read data, one cycle after mem_re_o
//    mem_addr_o/mem_re_o/mem_we_o       SRAM port; write data comes from the result buffer
//    op_a_o/op_b_o                      registered adder operands
//    loc_sel_o                          result buffer half select (0 = low, 1 = high)
//    busy_o/done_o                      run in progress / one-cycle end-of-run pulse
module calc_controller
   import calculator_pkg::*;
(
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     start_i,
   input  logic [ADDR_W-1:0]        rd_start_i,
   input  logic [ADDR_W-1:0]        rd_end_i,
   input  logic [ADDR_W-1:0]        wr_start_i,
   input  logic [ADDR_W-1:0]        wr_end_i,
   input  logic [MEM_WORD_SIZE-1:0] mem_rdata_i,
   output logic [ADDR_W-1:0]        mem_addr_o,
   output logic                     mem_re_o,
   output logic                     mem_we_o,
   output logic [DATA_W-1:0]        op_a_o,
   output logic [DATA_W-1:0]        op_b_o,
   output logic                     loc_sel_o,
   output logic                     busy_o,
   output logic                     done_o
);
   state_t state_q, state_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_end_q, wr_ptr_q, wr_end_q;
   logic [DATA_W-1:0] op_a_q, op_b_q;
   logic half_q, last_q, loc_q;
   // last_q marks that the most recently read word was the final one; a flag rather
   // than a pointer compare so a range ending at the top address cannot wrap around.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         rd_ptr_q <= '0;
         rd_end_q <= '0;
         wr_ptr_q <= '0;
         wr_end_q <= '0;
         op_a_q   <= '0;
         op_b_q   <= '0;
         half_q   <= 1'b0;
         last_q   <= 1'b0;
         loc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: if (start_i) begin
               rd_ptr_q <= rd_start_i;
               rd_end_q <= rd_end_i;
               wr_ptr_q <= wr_start_i;
               wr_end_q <= wr_end_i;
               half_q   <= 1'b0;
               last_q   <= 1'b0;
            end
            S_WAIT: begin
               op_a_q   <= mem_rdata_i[MEM_WORD_SIZE-1:DATA_W];
               op_b_q   <= mem_rdata_i[DATA_W-1:0];
               rd_ptr_q <= rd_ptr_q + 1'b1;
               last_q   <= (rd_ptr_q == rd_end_q);
            end
            S_ADD: begin
               half_q <= ~half_q;
               loc_q  <= half_q;
               // Operands must already be zero during S_FLUSH so the upper half captures 0.
               if (state_d == S_FLUSH) begin
                  op_a_q <= '0;
                  op_b_q <= '0;
               end
            end
            S_FLUSH: loc_q <= 1'b1;
            S_WRITE: wr_ptr_q <= wr_ptr_q + 1'b1;
            default: ;
         endcase
      end
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = !start_i ? S_IDLE :
                            (rd_end_i < rd_start_i || wr_end_i < wr_start_i) ? S_END : S_READ;
         S_READ:  state_d = S_WAIT;
         S_WAIT:  state_d = S_ADD;
         S_ADD:   state_d = half_q ? S_WRITE : last_q ? S_FLUSH : S_READ;
         S_FLUSH: state_d = S_WRITE;
         S_WRITE: state_d = (!last_q && wr_ptr_q < wr_end_q) ? S_READ : S_END;
         default: state_d = S_IDLE;
      endcase
   end
   always_comb begin
      mem_re_o   = (state_q == S_READ);
      mem_we_o   = (state_q == S_WRITE);
      mem_addr_o = (state_q == S_READ) ? rd_ptr_q : (state_q == S_WRITE) ? wr_ptr_q : '0;
      loc_sel_o  = (state_q == S_ADD) ? half_q : (state_q == S_FLUSH) ? 1'b1 : loc_q;
      op_a_o     = op_a_q;
      op_b_o     = op_b_q;
      busy_o     = (state_q != S_IDLE);
      done_o     = (state_q == S_END);
   end
endmodule

// File: tb/tb_calc_controller.sv
// tb_calc_controller: SRAM + result buffer environment and transaction-level model for calc_controller.
module tb_calc_controller;
   import calculator_pkg::*;
   logic clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0;
   logic [ADDR_W-1:0] rd_start_i = '0, rd_end_i = '0, wr_start_i = '0, wr_end_i = '0;
   logic [63:0] mem_rdata_i = '0;
   logic [ADDR_W-1:0] mem_addr_o;
   logic mem_re_o, mem_we_o, loc_sel_o, busy_o, done_o;
   logic [31:0] op_a_o, op_b_o;

   calc_controller dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
      .rd_start_i(rd_start_i), .rd_end_i(rd_end_i), .wr_start_i(wr_start_i), .wr_end_i(wr_end_i),
      .mem_rdata_i(mem_rdata_i), .mem_addr_o(mem_addr_o), .mem_re_o(mem_re_o), .mem_we_o(mem_we_o),
      .op_a_o(op_a_o), .op_b_o(op_b_o), .loc_sel_o(loc_sel_o), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;

   logic [63:0] mem [0:1023];
   logic [63:0] buf_q = '0;

   always @(posedge clk_i) begin
      if (mem_re_o) mem_rdata_i <= mem[mem_addr_o];
      if (mem_we_o) mem[mem_addr_o] = buf_q;
      if (loc_sel_o) buf_q[63:32] <= op_a_o + op_b_o;
      else buf_q[31:0] <= op_a_o + op_b_o;
   end

   int checks = 0, errors = 0;
   int exp_rd[$];
   int exp_wa[$];
   logic [63:0] exp_wd[$];
   int exp_done = 0, run_cyc = 0, n_re = 0, n_we = 0, tot_we = 0;
   bit armed = 0, done_seen = 0, quiet = 1;

   task automatic chk(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   always @(negedge clk_i) begin
      if (mem_we_o) tot_we++;
      if (mem_re_o || mem_we_o) chk("re_we_exclusive", {mem_re_o, mem_we_o} != 2'b11, 1);
      if (armed) begin
         run_cyc++;
         if (run_cyc >= 1) chk("busy_in_run", busy_o, 1);
         if (mem_re_o) begin
            n_re++;
            if (exp_rd.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_read actual addr=%0d required none", mem_addr_o);
            end else chk("read_addr", mem_addr_o, exp_rd.pop_front());
         end
         if (mem_we_o) begin
            n_we++;
            if (exp_wa.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_write actual addr=%0d required none", mem_addr_o);
            end else begin
               chk("write_addr", mem_addr_o, exp_wa.pop_front());
               chk("write_data", buf_q, exp_wd.pop_front());
            end
         end
         if (done_o) begin
            chk("done_cycle", run_cyc, exp_done);
            chk("reads_left", exp_rd.size(), 0);
            chk("writes_left", exp_wa.size(), 0);
            armed = 0;
            done_seen = 1;
         end
      end else if (quiet) chk("idle_quiet", {busy_o, done_o, mem_re_o, mem_we_o}, 0);
   end

   task automatic build_model(int rs, int re, int ws, int we);
      int words, slots, nr, nw, fl;
      logic [63:0] w0, w1;
      logic [31:0] lo, hi;
      exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
      words = (re >= rs && we >= ws) ? re - rs + 1 : 0;
      slots = (we >= ws) ? we - ws + 1 : 0;
      nr = 0; nw = 0; fl = 0;
      for (int w = 0; w < slots && 2 * w < words; w++) begin
         w0 = mem[rs + 2 * w];
         exp_rd.push_back(rs + 2 * w); nr++;
         lo = w0[63:32] + w0[31:0];
         if (2 * w + 1 < words) begin
            w1 = mem[rs + 2 * w + 1];
            exp_rd.push_back(rs + 2 * w + 1); nr++;
            hi = w1[63:32] + w1[31:0];
         end else begin
            hi = '0; fl = 1;
         end
         exp_wa.push_back(ws + w); exp_wd.push_back({hi, lo}); nw++;
      end
      exp_done = 3 * nr + nw + fl + 1;
   endtask

   task automatic run(int rs, int re, int ws, int we, int restart_at);
      build_model(rs, re, ws, we);
      @(posedge clk_i); #2;
      rd_start_i = ADDR_W'(rs); rd_end_i = ADDR_W'(re);
      wr_start_i = ADDR_W'(ws); wr_end_i = ADDR_W'(we);
      start_i = 1; run_cyc = -1; n_re = 0; n_we = 0; done_seen = 0; armed = 1;
      @(posedge clk_i); #2;
      start_i = 0;
      for (int i = 0; i < 4000 && !done_seen; i++) begin
         @(posedge clk_i); #2;
         if (i == restart_at) begin
            start_i = 1;
            rd_start_i = 10'd100; rd_end_i = 10'd120; wr_start_i = 10'd300; wr_end_i = 10'd310;
         end else start_i = 0;
      end
      start_i = 0;
      if (!done_seen) begin
         checks++; errors++;
         $display("FAIL run_timeout actual=no done required done by cycle %0d", exp_done);
         armed = 0;
      end
      repeat (2) @(posedge clk_i);
   endtask

   initial begin
      int rs, re, ws, we, ra, w0;
      for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
      #2;
      chk("reset_busy", busy_o, 0);
      chk("reset_flags", {done_o, mem_re_o, mem_we_o, loc_sel_o}, 0);
      chk("reset_addr", mem_addr_o, 0);
      chk("reset_ops", {op_a_o, op_b_o}, 0);
      @(posedge clk_i); #2; rst_ni = 1;
      repeat (2) @(posedge clk_i);

      // scenario 2: two words, one result slot
      mem[0] = {32'd1, 32'd2}; mem[1] = {32'd10, 32'd20}; mem[8] = '0;
      run(0, 1, 8, 8, -1);
      chk("s2_mem8", mem[8], 64'h0000001E_00000003);
      chk("s2_writes", n_we, 1);
      chk("s2_done_cyc", exp_done, 8);

      // scenario 3: odd count flushes upper half to zero
      mem[2] = {32'd5, 32'd5}; mem[9] = '1;
      run(0, 2, 8, 9, -1);
      chk("s3_mem8", mem[8], 64'h0000001E_00000003);
      chk("s3_mem9", mem[9], 64'h00000000_0000000A);

      // scenario 4: write range exhausted, rest of operands unread
      mem[8] = '0;
      run(0, 5, 8, 8, -1);
      chk("s4_reads", n_re, 2);
      chk("s4_writes", n_we, 1);
      chk("s4_mem8", mem[8], 64'h0000001E_00000003);

      // scenario 5: empty operand range
      run(4, 3, 8, 9, -1);
      chk("s5_reads", n_re, 0);
      chk("s5_writes", n_we, 0);
      chk("s5_done_seen", done_seen, 1);

      // scenario 6: restart while busy ignored; adder wrap
      mem[8] = '0;
      run(0, 1, 8, 8, 1);
      chk("s6_mem8", mem[8], 64'h0000001E_00000003);
      mem[0] = {32'hFFFFFFFF, 32'd1};
      run(0, 1, 8, 8, 3);
      chk("s6_wrap", mem[8], 64'h0000001E_00000000);

      // top-of-address boundaries terminate without wrapping
      run(1020, 1023, 1000, 1010, -1);
      chk("top_rd_writes", n_we, 2);
      run(0, 9, 1022, 1023, -1);
      chk("top_wr_writes", n_we, 2);
      chk("top_wr_reads", n_re, 4);

      // scenario 1: reset during S_WAIT
      quiet = 0;
      mem[8] = '0;
      @(posedge clk_i); #2;
      rd_start_i = 10'd0; rd_end_i = 10'd5; wr_start_i = 10'd8; wr_end_i = 10'd9;
      start_i = 1;
      @(posedge clk_i); #2; start_i = 0;
      @(posedge clk_i); #2;
      chk("s1_in_wait_busy", busy_o, 1);
      rst_ni = 0;
      @(posedge clk_i); #2;
      chk("s1_busy", busy_o, 0);
      chk("s1_re_we", {mem_re_o, mem_we_o}, 0);
      rst_ni = 1;
      w0 = tot_we;
      repeat (12) @(posedge clk_i);
      chk("s1_no_writes", tot_we, w0);
      chk("s1_mem8", mem[8], 0);
      #2; quiet = 1;

      // randomized runs with disjoint operand/result regions
      for (int k = 0; k < 25; k++) begin
         rs = $urandom_range(1, 400);
         re = ($urandom_range(0, 7) == 0) ? rs - 1 : rs + $urandom_range(0, 12);
         ws = 512 + $urandom_range(0, 400);
         we = ws + $urandom_range(0, 6);
         build_model(rs, re, ws, we);
         ra = (exp_done > 3 && $urandom_range(0, 1) == 1) ? $urandom_range(0, exp_done - 3) : -1;
         run(rs, re, ws, we, ra);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
